// File: rtl/decode_ctrl_pipe.sv
// ---------------------------------------------------------------------------
// decode_ctrl_pipe
// Single-stage instruction decode with a registered control word, a
// valid/ready handshake on both sides and a load-use interlock.
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : upstream handshake
//   branch_i, imm_i,
//   code_i, rd_i, rs_i  : instruction fields (only code_i[2:0] is decoded)
//   flush_i             : discards the output register and any bubble
//   out_valid/out_ready : downstream handshake
//   regw, memw, memr,
//   flagw, reg1_sel,
//   imm_sel, alu_ctrl,
//   rd_o                : registered control word
//   stall_o             : high while a load-use bubble is being inserted
// ---------------------------------------------------------------------------
module decode_ctrl_pipe #(
    parameter int OPW    = 3,
    parameter int RAW    = 4,
    parameter int LD_LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           branch_i,
    input  logic           imm_i,
    input  logic [OPW-1:0] code_i,
    input  logic [RAW-1:0] rd_i,
    input  logic [RAW-1:0] rs_i,
    input  logic           flush_i,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           regw,
    output logic           memw,
    output logic           memr,
    output logic           flagw,
    output logic           reg1_sel,
    output logic [1:0]     imm_sel,
    output logic [1:0]     alu_ctrl,
    output logic [RAW-1:0] rd_o,
    output logic           stall_o
);

    localparam logic [0:0] RUN    = 1'b0;
    localparam logic [0:0] BUBBLE = 1'b1;

    localparam logic [2:0] LOAD_CNT = 3'(LD_LAT - 1);

    logic [0:0] state;
    logic [2:0] cnt;

    logic       d_regw;
    logic       d_memw;
    logic       d_memr;
    logic       d_flagw;
    logic       d_reg1_sel;
    logic [1:0] d_imm_sel;
    logic [1:0] d_alu;

    logic       hazard;
    logic       xfer;

    // Combinational decode of the incoming instruction. Branches never write
    // anything; with an immediate their ALU op comes from code bit 2.
    always_comb begin
        d_regw  = 1'b0;
        d_memw  = 1'b0;
        d_memr  = 1'b0;
        d_flagw = 1'b0;
        d_alu   = 2'b11;
        if (branch_i) begin
            d_alu = imm_i ? {1'b0, code_i[2]} : 2'b11;
        end else begin
            case (code_i[2:0])
                3'b000: d_alu = 2'b11;
                3'b001: begin d_alu = 2'b00; d_regw = 1'b1; end
                3'b010: begin d_alu = 2'b01; d_regw = 1'b1; end
                3'b011: begin d_alu = 2'b10; d_regw = 1'b1; end
                3'b100: begin d_alu = 2'b11; d_regw = 1'b1; end
                3'b101: begin d_alu = 2'b01; d_flagw = 1'b1; end
                3'b110: begin d_alu = 2'b11; d_memw = 1'b1; end
                default: begin d_alu = 2'b11; d_regw = 1'b1; d_memr = 1'b1; end
            endcase
        end
        d_reg1_sel = !branch_i && (d_memr ^ d_regw);
        d_imm_sel  = {branch_i, code_i[2]};
    end

    // Load-use check against the word currently held in the output register.
    // out_valid qualifies it so a load that has already been consumed
    // downstream cannot keep re-triggering bubbles. A hazard also drops
    // in_ready, so the dependent instruction is not accepted upstream.
    assign hazard = (state == RUN) && out_valid && memr && in_valid &&
                    ((rs_i == rd_o) || (rd_i == rd_o));

    assign in_ready = (!out_valid || out_ready) && (state == RUN) &&
                      !flush_i && !hazard;
    assign xfer     = in_valid && in_ready;
    assign stall_o  = (state == BUBBLE);

    // Interlock FSM: a hazard loads the counter with LD_LAT-1 and the bubble
    // ends on the cycle the counter reads zero, giving exactly LD_LAT stall
    // cycles. Flush overrides everything and returns to RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= 3'd0;
        end else if (flush_i) begin
            state <= RUN;
            cnt   <= 3'd0;
        end else begin
            case (state)
                RUN: begin
                    if (hazard) begin
                        state <= BUBBLE;
                        cnt   <= LOAD_CNT;
                    end
                end
                BUBBLE: begin
                    if (cnt == 3'd0) begin
                        state <= RUN;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= 3'd0;
                end
            endcase
        end
    end

    // Output register. Flush kills the valid bit and every write enable but
    // leaves the non-destructive fields alone; an accepted word with nothing
    // behind it just drops out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            regw      <= 1'b0;
            memw      <= 1'b0;
            memr      <= 1'b0;
            flagw     <= 1'b0;
            reg1_sel  <= 1'b0;
            imm_sel   <= 2'b00;
            alu_ctrl  <= 2'b00;
            rd_o      <= '0;
        end else if (flush_i) begin
            out_valid <= 1'b0;
            regw      <= 1'b0;
            memw      <= 1'b0;
            memr      <= 1'b0;
            flagw     <= 1'b0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            regw      <= d_regw;
            memw      <= d_memw;
            memr      <= d_memr;
            flagw     <= d_flagw;
            reg1_sel  <= d_reg1_sel;
            imm_sel   <= d_imm_sel;
            alu_ctrl  <= d_alu;
            rd_o      <= rd_i;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// ---------------------------------------------------------------------------
// tb_decode_ctrl_pipe
// Directed bench for decode_ctrl_pipe (OPW=4 so the ignored code bit is
// exercised, LD_LAT=2). A behavioural model tracks the expected output
// register and remaining bubble cycles; a negedge process compares every
// output against it each cycle, and the directed sequence adds literal
// expectations at the interesting points.
// ---------------------------------------------------------------------------
module tb_decode_ctrl_pipe;

    localparam int OPW    = 4;
    localparam int RAW    = 4;
    localparam int LD_LAT = 2;

    typedef struct packed {
        logic [1:0] alu;
        logic [1:0] imm_sel;
        logic       regw;
        logic       memw;
        logic       memr;
        logic       flagw;
        logic       reg1;
    } dec_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic           branch_i;
    logic           imm_i;
    logic [OPW-1:0] code_i;
    logic [RAW-1:0] rd_i;
    logic [RAW-1:0] rs_i;
    logic           flush_i;
    logic           out_valid;
    logic           out_ready;
    logic           regw;
    logic           memw;
    logic           memr;
    logic           flagw;
    logic           reg1_sel;
    logic [1:0]     imm_sel;
    logic [1:0]     alu_ctrl;
    logic [RAW-1:0] rd_o;
    logic           stall_o;

    int n_compared = 0;
    int n_failed   = 0;

    // Non-branch behaviour per opcode: {alu[1:0], regw, memw, memr, flagw}
    logic [5:0] nb_tab [0:7] = '{6'b110000, 6'b001000, 6'b011000, 6'b101000,
                                 6'b111000, 6'b010001, 6'b110100, 6'b111010};

    decode_ctrl_pipe #(.OPW(OPW), .RAW(RAW), .LD_LAT(LD_LAT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .branch_i(branch_i), .imm_i(imm_i), .code_i(code_i),
        .rd_i(rd_i), .rs_i(rs_i), .flush_i(flush_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .regw(regw), .memw(memw), .memr(memr), .flagw(flagw),
        .reg1_sel(reg1_sel), .imm_sel(imm_sel), .alu_ctrl(alu_ctrl),
        .rd_o(rd_o), .stall_o(stall_o)
    );

    always #5 clk = ~clk;

    // Expected decode straight from the opcode table and branch rules.
    function automatic dec_t model_decode(input logic br, input logic im,
                                          input logic [OPW-1:0] code);
        dec_t d;
        logic [5:0] e;
        d = '0;
        d.imm_sel = {br, code[2]};
        if (br) begin
            d.alu = im ? {1'b0, code[2]} : 2'b11;
        end else begin
            e = nb_tab[code[2:0]];
            d.alu   = e[5:4];
            d.regw  = e[3];
            d.memw  = e[2];
            d.memr  = e[1];
            d.flagw = e[0];
            d.reg1  = d.memr ^ d.regw;
        end
        return d;
    endfunction

    logic           m_valid;
    dec_t           m_dec;
    logic [RAW-1:0] m_rd;
    int             m_bubble;
    logic           m_hazard;
    logic           m_ready;

    assign m_hazard = (m_bubble == 0) && m_valid && m_dec.memr && in_valid &&
                      ((rs_i == m_rd) || (rd_i == m_rd));
    assign m_ready  = (!m_valid || out_ready) && (m_bubble == 0) &&
                      !flush_i && !m_hazard;

    // Model of the output register and remaining bubble length
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid  <= 1'b0;
            m_dec    <= '0;
            m_rd     <= '0;
            m_bubble <= 0;
        end else if (flush_i) begin
            m_valid      <= 1'b0;
            m_dec.regw   <= 1'b0;
            m_dec.memw   <= 1'b0;
            m_dec.memr   <= 1'b0;
            m_dec.flagw  <= 1'b0;
            m_bubble     <= 0;
        end else begin
            if (m_hazard) m_bubble <= LD_LAT;
            else if (m_bubble > 0) m_bubble <= m_bubble - 1;
            if (in_valid && m_ready) begin
                m_valid <= 1'b1;
                m_dec   <= model_decode(branch_i, imm_i, code_i);
                m_rd    <= rd_i;
            end else if (out_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [7:0] act,
                               input logic [7:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        checkOutput("cyc out_valid", 8'(out_valid), 8'(m_valid));
        checkOutput("cyc in_ready",  8'(in_ready),  8'(m_ready));
        checkOutput("cyc stall_o",   8'(stall_o),   8'(m_bubble > 0));
        checkOutput("cyc regw",      8'(regw),      8'(m_dec.regw));
        checkOutput("cyc memw",      8'(memw),      8'(m_dec.memw));
        checkOutput("cyc memr",      8'(memr),      8'(m_dec.memr));
        checkOutput("cyc flagw",     8'(flagw),     8'(m_dec.flagw));
        checkOutput("cyc reg1_sel",  8'(reg1_sel),  8'(m_dec.reg1));
        checkOutput("cyc imm_sel",   8'(imm_sel),   8'(m_dec.imm_sel));
        checkOutput("cyc alu_ctrl",  8'(alu_ctrl),  8'(m_dec.alu));
        checkOutput("cyc rd_o",      8'(rd_o),      8'(m_rd));
    end

    task automatic applyStimulus(input logic iv, input logic br, input logic im,
                                 input logic [OPW-1:0] code, input logic [RAW-1:0] rd,
                                 input logic [RAW-1:0] rs, input logic fl,
                                 input logic ordy);
        in_valid  = iv;
        branch_i  = br;
        imm_i     = im;
        code_i    = code;
        rd_i      = rd;
        rs_i      = rs;
        flush_i   = fl;
        out_ready = ordy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst out_valid", 8'(out_valid), 8'h0);
        checkOutput("rst stall_o",   8'(stall_o),   8'h0);
        checkOutput("rst alu_ctrl",  8'(alu_ctrl),  8'h0);
        checkOutput("rst imm_sel",   8'(imm_sel),   8'h0);
        checkOutput("rst rd_o",      8'(rd_o),      8'h0);
        rst = 1'b0;
        #1;
        checkOutput("post-rst in_ready", 8'(in_ready), 8'h1);

        // ADD (code 001) -> one cycle later
        applyStimulus(1, 0, 0, 4'b0001, 4'd2, 4'd1, 0, 1);
        tick();
        checkOutput("add out_valid", 8'(out_valid), 8'h1);
        checkOutput("add regw",      8'(regw),      8'h1);
        checkOutput("add alu_ctrl",  8'(alu_ctrl),  8'h0);
        checkOutput("add reg1_sel",  8'(reg1_sel),  8'h1);
        checkOutput("add imm_sel",   8'(imm_sel),   8'h0);
        checkOutput("add rd_o",      8'(rd_o),      8'h2);

        // Load rd=3 then dependent ADD rs=3: two bubble cycles
        applyStimulus(1, 0, 0, 4'b0111, 4'd3, 4'd0, 0, 1);
        tick();
        checkOutput("ld memr",     8'(memr),     8'h1);
        checkOutput("ld reg1_sel", 8'(reg1_sel), 8'h0);
        applyStimulus(1, 0, 0, 4'b0001, 4'd4, 4'd3, 0, 1);
        checkOutput("dep in_ready", 8'(in_ready), 8'h0);
        tick();
        checkOutput("bub1 stall_o",  8'(stall_o),  8'h1);
        checkOutput("bub1 in_ready", 8'(in_ready), 8'h0);
        tick();
        checkOutput("bub2 stall_o",  8'(stall_o),  8'h1);
        checkOutput("bub2 in_ready", 8'(in_ready), 8'h0);
        tick();
        checkOutput("bub end stall_o",  8'(stall_o),  8'h0);
        checkOutput("bub end in_ready", 8'(in_ready), 8'h1);
        tick();
        checkOutput("dep add valid", 8'(out_valid), 8'h1);
        checkOutput("dep add rd_o",  8'(rd_o),      8'h4);

        // Load rd=3 then independent rs=5 rd=6: back-to-back
        applyStimulus(1, 0, 0, 4'b0111, 4'd3, 4'd0, 0, 1);
        tick();
        applyStimulus(1, 0, 0, 4'b0010, 4'd6, 4'd5, 0, 1);
        checkOutput("indep in_ready", 8'(in_ready), 8'h1);
        tick();
        checkOutput("indep stall_o",  8'(stall_o),  8'h0);
        checkOutput("indep rd_o",     8'(rd_o),     8'h6);
        checkOutput("indep alu_ctrl", 8'(alu_ctrl), 8'h1);

        // Branch with immediate, code 100 (upper code bit set, ignored)
        applyStimulus(1, 1, 1, 4'b1100, 4'd7, 4'd0, 0, 1);
        tick();
        checkOutput("br alu_ctrl", 8'(alu_ctrl), 8'h1);
        checkOutput("br imm_sel",  8'(imm_sel),  8'h3);
        checkOutput("br regw",     8'(regw),     8'h0);
        checkOutput("br memw",     8'(memw),     8'h0);
        applyStimulus(1, 1, 0, 4'b0010, 4'd7, 4'd0, 0, 1);
        tick();
        checkOutput("br2 alu_ctrl", 8'(alu_ctrl), 8'h3);
        checkOutput("br2 imm_sel",  8'(imm_sel),  8'h2);

        // Downstream backpressure for 3 cycles
        applyStimulus(1, 0, 0, 4'b0101, 4'd8, 4'd9, 0, 1);
        tick();
        applyStimulus(1, 0, 0, 4'b0011, 4'd9, 4'd10, 0, 0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("hold in_ready", 8'(in_ready), 8'h0);
            tick();
            checkOutput("hold rd_o",  8'(rd_o),  8'h8);
            checkOutput("hold flagw", 8'(flagw), 8'h1);
        end
        applyStimulus(1, 0, 0, 4'b0011, 4'd9, 4'd10, 0, 1);
        checkOutput("release in_ready", 8'(in_ready), 8'h1);
        tick();
        checkOutput("held insn rd_o", 8'(rd_o),     8'h9);
        checkOutput("held insn alu",  8'(alu_ctrl), 8'h2);
        applyStimulus(0, 0, 0, 4'b0000, 4'd0, 4'd0, 0, 1);
        tick();
        checkOutput("drain out_valid", 8'(out_valid), 8'h0);

        // Flush during a bubble
        applyStimulus(1, 0, 0, 4'b0111, 4'd1, 4'd0, 0, 1);
        tick();
        applyStimulus(1, 0, 0, 4'b0001, 4'd2, 4'd1, 0, 1);
        tick();
        checkOutput("pre-flush stall", 8'(stall_o), 8'h1);
        applyStimulus(1, 0, 0, 4'b0001, 4'd2, 4'd1, 1, 1);
        checkOutput("flush in_ready", 8'(in_ready), 8'h0);
        tick();
        checkOutput("flush stall_o",   8'(stall_o),   8'h0);
        checkOutput("flush out_valid", 8'(out_valid), 8'h0);
        applyStimulus(1, 0, 0, 4'b0001, 4'd2, 4'd1, 0, 1);
        checkOutput("post-flush in_ready", 8'(in_ready), 8'h1);
        tick();
        checkOutput("post-flush valid", 8'(out_valid), 8'h1);

        // Flush coinciding with a transfer
        applyStimulus(1, 0, 0, 4'b0001, 4'd5, 4'd0, 1, 1);
        tick();
        checkOutput("flush xfer valid", 8'(out_valid), 8'h0);
        checkOutput("flush xfer regw",  8'(regw),      8'h0);

        // Reset in the middle of a bubble
        applyStimulus(1, 0, 0, 4'b0111, 4'd1, 4'd0, 0, 1);
        tick();
        applyStimulus(1, 0, 0, 4'b0001, 4'd2, 4'd1, 0, 1);
        tick();
        checkOutput("pre-rst stall", 8'(stall_o), 8'h1);
        rst = 1'b1;
        #1;
        checkOutput("async rst stall", 8'(stall_o),   8'h0);
        checkOutput("async rst valid", 8'(out_valid), 8'h0);
        checkOutput("async rst regw",  8'(regw),      8'h0);
        checkOutput("async rst memr",  8'(memr),      8'h0);
        checkOutput("async rst rd_o",  8'(rd_o),      8'h0);
        tick();
        applyStimulus(0, 0, 0, 4'b0000, 4'd0, 4'd0, 0, 1);
        rst = 1'b0;
        #1;
        checkOutput("rst release in_ready", 8'(in_ready), 8'h1);
        applyStimulus(1, 0, 0, 4'b0100, 4'd11, 4'd0, 0, 1);
        tick();
        checkOutput("resume valid", 8'(out_valid), 8'h1);
        checkOutput("resume alu",   8'(alu_ctrl),  8'h3);
        applyStimulus(0, 0, 0, 4'b0000, 4'd0, 4'd0, 0, 1);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
